// File: rtl/exec_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, operand selects, branch funct3 codes
// and the iterative multiplier state type.
package exec_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluSll   = 4'b0010;
  localparam logic [3:0] AluSlt   = 4'b0011;
  localparam logic [3:0] AluSltu  = 4'b0100;
  localparam logic [3:0] AluXor   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluOr    = 4'b1000;
  localparam logic [3:0] AluAnd   = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;
  localparam logic [3:0] AluMul   = 4'b1011;

  localparam logic [1:0] SrcAReg  = 2'b00;
  localparam logic [1:0] SrcAPc   = 2'b01;
  localparam logic [1:0] SrcAZero = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;
  localparam logic [1:0] SrcBZero = 2'b11;

  localparam logic [2:0] BrEq   = 3'b000;
  localparam logic [2:0] BrNe   = 3'b001;
  localparam logic [2:0] BrJal  = 3'b010;
  localparam logic [2:0] BrJalr = 3'b011;
  localparam logic [2:0] BrLt   = 3'b100;
  localparam logic [2:0] BrGe   = 3'b101;
  localparam logic [2:0] BrLtu  = 3'b110;
  localparam logic [2:0] BrGeu  = 3'b111;

  typedef enum logic [1:0] {MulIdle, MulBusy, MulDone} mulState_e;

  function automatic logic branchTaken(logic [2:0] funct3, logic eq, logic lt, logic ltu);
    logic taken;
    case (funct3)
      BrEq:           taken = eq;
      BrNe:           taken = ~eq;
      BrJal, BrJalr:  taken = 1'b1;
      BrLt:           taken = lt;
      BrGe:           taken = ~lt;
      BrLtu:          taken = ltu;
      BrGeu:          taken = ~ltu;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one step per cycle, low XLEN bits of unsigned product,
// done is high for the single cycle after the last step.
module mul_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CntW = $clog2(XLEN);

  mulState_e       stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [XLEN-1:0] mcandQ, mcandD;
  logic [XLEN-1:0] mplierQ, mplierD;
  logic [XLEN-1:0] accQ, accD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= MulIdle;
      cntQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      accQ    <= accD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    mcandD  = mcandQ;
    mplierD = mplierQ;
    accD    = accQ;
    case (stateQ)
      MulIdle: begin
        if (start) begin
          stateD  = MulBusy;
          cntD    = '0;
          mcandD  = opA;
          mplierD = opB;
          accD    = '0;
        end
      end
      MulBusy: begin
        if (mplierQ[0]) accD = accQ + mcandQ;
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        cntD    = cntQ + CntW'(1);
        if (cntQ == CntW'(XLEN - 1)) stateD = MulDone;
      end
      MulDone: stateD = MulIdle;
      default: stateD = MulIdle;
    endcase
  end

  assign done    = (stateQ == MulDone);
  assign product = accQ;

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand select, ALU, branch/jump resolution and the EX/MEM register.
// Define MUL_EN to add the iterative multiplier (ALUop 1011), which stalls the front of the pipe.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            MemtoRegE,
  input  logic            PCBranchE,
  input  logic [2:0]      strCtrlE,
  input  logic [3:0]      ALUopE,
  input  logic [1:0]      SrcASelE,
  input  logic [1:0]      SrcBSelE,
  input  logic [XLEN-1:0] immE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] r1E,
  input  logic [XLEN-1:0] r2E,
  input  logic [4:0]      rdE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            stallE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemtoRegM,
  output logic [2:0]      strCtrlM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      rdM
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [XLEN-1:0] srcA, srcB, aluResult;
  logic [XLEN-1:0] pcRelTarget, jalrSum;
  logic [ShW-1:0]  shamt;
  logic            sltAB, sltuAB;
  logic            eqR, ltR, ltuR;

  always_comb begin
    case (SrcASelE)
      SrcAReg: srcA = r1E;
      SrcAPc:  srcA = PCE;
      default: srcA = '0;
    endcase
  end

  always_comb begin
    case (SrcBSelE)
      SrcBReg:  srcB = r2E;
      SrcBImm:  srcB = immE;
      SrcBFour: srcB = XLEN'(4);
      default:  srcB = '0;
    endcase
  end

`ifdef MUL_EN
  logic            mulOp, mulDone;
  logic [XLEN-1:0] mulProduct;

  assign mulOp = (ALUopE == AluMul);

  mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mulOp),
    .opA    (srcA),
    .opB    (srcB),
    .done   (mulDone),
    .product(mulProduct)
  );

  // Reset gates the stall so an aborted multiply releases the pipe at once.
  assign stallE = mulOp & ~mulDone & ~rst;
`else
  assign stallE = 1'b0;
`endif

  assign shamt  = srcB[ShW-1:0];
  assign sltAB  = $signed(srcA) < $signed(srcB);
  assign sltuAB = srcA < srcB;

  always_comb begin
    aluResult = '0;
    case (ALUopE)
      AluAdd:   aluResult = srcA + srcB;
      AluSub:   aluResult = srcA - srcB;
      AluSll:   aluResult = srcA << shamt;
      AluSlt:   aluResult = XLEN'(sltAB);
      AluSltu:  aluResult = XLEN'(sltuAB);
      AluXor:   aluResult = srcA ^ srcB;
      AluSrl:   aluResult = srcA >> shamt;
      AluSra:   aluResult = XLEN'($signed(srcA) >>> shamt);
      AluOr:    aluResult = srcA | srcB;
      AluAnd:   aluResult = srcA & srcB;
      AluPassB: aluResult = srcB;
`ifdef MUL_EN
      AluMul:   aluResult = mulProduct;
`endif
      default:  aluResult = '0;
    endcase
  end

  // Branch conditions compare the raw register operands, independent of the ALU selects.
  assign eqR  = (r1E == r2E);
  assign ltR  = $signed(r1E) < $signed(r2E);
  assign ltuR = r1E < r2E;

  assign pcRelTarget = PCE + immE;
  assign jalrSum     = r1E + immE;

  assign PCSrcE    = PCBranchE & branchTaken(strCtrlE, eqR, ltR, ltuR);
  assign PCTargetE = (PCBranchE && strCtrlE == BrJalr) ? {jalrSum[XLEN-1:1], 1'b0}
                                                       : pcRelTarget;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      strCtrlM   <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      rdM        <= '0;
    end else if (stallE) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      strCtrlM   <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      rdM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      MemtoRegM  <= MemtoRegE;
      strCtrlM   <= strCtrlE;
      ALUResultM <= aluResult;
      WriteDataM <= r2E;
      rdM        <= rdE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table with an EX/MEM scoreboard, plus
// reset and (under MUL_EN) multiplier stall sequences.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, MemtoRegE, PCBranchE;
  logic [2:0]  strCtrlE;
  logic [3:0]  ALUopE;
  logic [1:0]  SrcASelE, SrcBSelE;
  logic [31:0] immE, PCE, r1E, r2E;
  logic [4:0]  rdE;
  logic        PCSrcE, stallE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, MemtoRegM;
  logic [2:0]  strCtrlM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  rdM;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .PCBranchE(PCBranchE),
    .strCtrlE(strCtrlE), .ALUopE(ALUopE), .SrcASelE(SrcASelE), .SrcBSelE(SrcBSelE),
    .immE(immE), .PCE(PCE), .r1E(r1E), .r2E(r2E), .rdE(rdE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .stallE(stallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .strCtrlM(strCtrlM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .rdM(rdM)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [1:0]  aSel, bSel;
    logic        br;
    logic [2:0]  str;
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  rd;
    logic        rw, mw, m2r;
    logic        expSrc;
    logic [31:0] expTgt, expAlu;
  } vec_t;

  typedef struct {
    string       name;
    logic        rw, mw, m2r;
    logic [2:0]  str;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic [3:0] op, input logic [1:0] aSel,
                        input logic [1:0] bSel, input logic br, input logic [2:0] str,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [4:0] rd, input logic rw,
                        input logic mw, input logic m2r, input logic expSrc,
                        input logic [31:0] expTgt, input logic [31:0] expAlu);
    vec_t v;
    v.name = name; v.op = op; v.aSel = aSel; v.bSel = bSel; v.br = br; v.str = str;
    v.pc = pc; v.imm = imm; v.r1 = r1; v.r2 = r2; v.rd = rd;
    v.rw = rw; v.mw = mw; v.m2r = m2r;
    v.expSrc = expSrc; v.expTgt = expTgt; v.expAlu = expAlu;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    ALUopE = v.op; SrcASelE = v.aSel; SrcBSelE = v.bSel; PCBranchE = v.br; strCtrlE = v.str;
    PCE = v.pc; immE = v.imm; r1E = v.r1; r2E = v.r2; rdE = v.rd;
    RegWriteE = v.rw; MemWriteE = v.mw; MemtoRegE = v.m2r;
  endtask

  task automatic pushExp(input vec_t v, input logic [31:0] alu);
    exp_t e;
    e.name = v.name; e.rw = v.rw; e.mw = v.mw; e.m2r = v.m2r; e.str = v.str;
    e.alu = alu; e.wd = v.r2; e.rd = v.rd;
    sb.push_back(e);
  endtask

  task automatic checkEm();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got output with no expected entry");
    end else begin
      e = sb.pop_front();
      check({e.name, ".RegWriteM"}, 32'(RegWriteM), 32'(e.rw));
      check({e.name, ".MemWriteM"}, 32'(MemWriteM), 32'(e.mw));
      check({e.name, ".MemtoRegM"}, 32'(MemtoRegM), 32'(e.m2r));
      check({e.name, ".strCtrlM"}, 32'(strCtrlM), 32'(e.str));
      check({e.name, ".ALUResultM"}, ALUResultM, e.alu);
      check({e.name, ".WriteDataM"}, WriteDataM, e.wd);
      check({e.name, ".rdM"}, 32'(rdM), 32'(e.rd));
    end
  endtask

  task automatic checkZero(input string name);
    check({name, ".RegWriteM"}, 32'(RegWriteM), 32'd0);
    check({name, ".MemWriteM"}, 32'(MemWriteM), 32'd0);
    check({name, ".MemtoRegM"}, 32'(MemtoRegM), 32'd0);
    check({name, ".strCtrlM"}, 32'(strCtrlM), 32'd0);
    check({name, ".ALUResultM"}, ALUResultM, 32'd0);
    check({name, ".WriteDataM"}, WriteDataM, 32'd0);
    check({name, ".rdM"}, 32'(rdM), 32'd0);
    check({name, ".stallE"}, 32'(stallE), 32'd0);
  endtask

  function automatic vec_t mulVec(input string name, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd);
    vec_t v;
    v.name = name; v.op = 4'b1011; v.aSel = 2'b00; v.bSel = 2'b00; v.br = 1'b0; v.str = 3'b000;
    v.pc = 32'h0; v.imm = 32'h0; v.r1 = a; v.r2 = b; v.rd = rd;
    v.rw = 1'b1; v.mw = 1'b0; v.m2r = 1'b0;
    v.expSrc = 1'b0; v.expTgt = 32'h0; v.expAlu = 32'h0;
    return v;
  endfunction

`ifdef MUL_EN
  // Caller is at a negedge with the FSM idle; presents the MUL and follows it to capture.
  task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] prod);
    vec_t v;
    int   stalls, bubbles, edges;
    bit   got, st;
    v = mulVec(name, a, b, rd);
    drive(v);
    pushExp(v, prod);
    stalls = 0; bubbles = 0; edges = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      st = stallE;
      check({name, ".PCSrcE"}, 32'(PCSrcE), 32'd0);
      @(posedge clk);
      #1;
      edges++;
      if (st) begin
        stalls++;
        if (!RegWriteM && !MemWriteM && !MemtoRegM && strCtrlM == 3'b0 && ALUResultM == 32'h0
            && WriteDataM == 32'h0 && rdM == 5'h0) bubbles++;
      end else begin
        got = 1;
        checkEm();
      end
      if (!got) @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no product within 60 edges, expected 34", name);
      sb.delete();
    end
    check({name, ".stall_cycles"}, 32'(stalls), 32'd33);
    check({name, ".bubbles"}, 32'(bubbles), 32'd33);
    check({name, ".edges"}, 32'(edges), 32'd34);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //      name     op     aS     bS     br    str     pc            imm           r1            r2            rd     rw mw m2r src tgt           alu
    addVec("add",   4'h0, 2'b00, 2'b01, 1'b0, 3'b000, 32'h0,        32'hFFFFFFFD, 32'd5,        32'h0,        5'd7,  1, 0, 0, 0, 32'hFFFFFFFD, 32'd2);
    addVec("sub",   4'h1, 2'b00, 2'b00, 1'b0, 3'b000, 32'h10,       32'h0,        32'd3,        32'd5,        5'd8,  1, 0, 0, 0, 32'h10,       32'hFFFFFFFE);
    addVec("sll",   4'h2, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'd1,        32'h23,       5'd9,  1, 0, 0, 0, 32'h0,        32'd8);
    addVec("slt",   4'h3, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd1,        5'd10, 1, 0, 0, 0, 32'h0,        32'd1);
    addVec("sltu",  4'h4, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd1,        5'd11, 1, 0, 0, 0, 32'h0,        32'd0);
    addVec("xor",   4'h5, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 5'd12, 1, 0, 0, 0, 32'h0,        32'h0FF00FF0);
    addVec("srl",   4'h6, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'h80000000, 32'd4,        5'd13, 1, 0, 0, 0, 32'h0,        32'h08000000);
    addVec("sra",   4'h7, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'h80000000, 32'd4,        5'd14, 1, 0, 0, 0, 32'h0,        32'hF8000000);
    addVec("ori",   4'h8, 2'b00, 2'b01, 1'b0, 3'b000, 32'h0,        32'hF,        32'h0000F000, 32'h0,        5'd15, 1, 0, 0, 0, 32'hF,        32'h0000F00F);
    addVec("and",   4'h9, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'hFFFF00FF, 32'h0F0F0F0F, 5'd16, 1, 0, 0, 0, 32'h0,        32'h0F0F000F);
    addVec("passb", 4'hA, 2'b10, 2'b01, 1'b0, 3'b000, 32'h0,        32'h12345000, 32'h0,        32'h0,        5'd17, 1, 0, 0, 0, 32'h12345000, 32'h12345000);
    addVec("undef", 4'hC, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0,        32'h0,        32'd5,        32'd6,        5'd18, 1, 0, 0, 0, 32'h0,        32'h0);
    addVec("zsel",  4'h0, 2'b11, 2'b11, 1'b0, 3'b000, 32'h4,        32'h8,        32'h55,       32'h66,       5'd19, 1, 0, 0, 0, 32'hC,        32'h0);
    addVec("four",  4'h0, 2'b10, 2'b10, 1'b0, 3'b000, 32'h0,        32'h0,        32'h55,       32'h0,        5'd20, 1, 0, 0, 0, 32'h0,        32'd4);
    addVec("beq_t", 4'h1, 2'b00, 2'b00, 1'b1, 3'b000, 32'h100,      32'h20,       32'd9,        32'd9,        5'd0,  0, 0, 0, 1, 32'h120,      32'h0);
    addVec("beq_n", 4'h1, 2'b00, 2'b00, 1'b1, 3'b000, 32'h100,      32'h20,       32'd9,        32'd8,        5'd0,  0, 0, 0, 0, 32'h120,      32'd1);
    addVec("bne",   4'h1, 2'b00, 2'b00, 1'b1, 3'b001, 32'h100,      32'h20,       32'd9,        32'd8,        5'd0,  0, 0, 0, 1, 32'h120,      32'd1);
    addVec("blt",   4'h1, 2'b00, 2'b00, 1'b1, 3'b100, 32'h200,      32'hFFFFFFF0, 32'hFFFFFFFE, 32'd1,        5'd0,  0, 0, 0, 1, 32'h1F0,      32'hFFFFFFFD);
    addVec("bge",   4'h1, 2'b00, 2'b00, 1'b1, 3'b101, 32'h200,      32'hFFFFFFF0, 32'hFFFFFFFE, 32'd1,        5'd0,  0, 0, 0, 0, 32'h1F0,      32'hFFFFFFFD);
    addVec("bltu",  4'h1, 2'b00, 2'b00, 1'b1, 3'b110, 32'h200,      32'hFFFFFFF0, 32'hFFFFFFFE, 32'd1,        5'd0,  0, 0, 0, 0, 32'h1F0,      32'hFFFFFFFD);
    addVec("bgeu",  4'h1, 2'b00, 2'b00, 1'b1, 3'b111, 32'h200,      32'hFFFFFFF0, 32'hFFFFFFFE, 32'd1,        5'd0,  0, 0, 0, 1, 32'h1F0,      32'hFFFFFFFD);
    addVec("jal",   4'h0, 2'b01, 2'b10, 1'b1, 3'b010, 32'h80,       32'h100,      32'h0,        32'h0,        5'd1,  1, 0, 0, 1, 32'h180,      32'h84);
    addVec("jalr",  4'h0, 2'b01, 2'b10, 1'b1, 3'b011, 32'h40,       32'd2,        32'h1001,     32'h0,        5'd1,  1, 0, 0, 1, 32'h1002,     32'h44);
    addVec("load",  4'h0, 2'b00, 2'b01, 1'b0, 3'b100, 32'h300,      32'hFFFFFFFC, 32'h2000,     32'h0,        5'd21, 1, 0, 1, 0, 32'h2FC,      32'h1FFC);
    addVec("store", 4'h0, 2'b00, 2'b01, 1'b0, 3'b010, 32'h0,        32'd8,        32'h1000,     32'hDEADBEEF, 5'd0,  0, 1, 0, 0, 32'd8,        32'h1008);

    // Reset with a MUL presented: stall must stay low while rst is high.
    rst = 1'b1;
    drive(mulVec("rst_mul", 32'd3, 32'd5, 5'd3));
    repeat (2) @(negedge clk);
    #1;
    checkZero("reset");

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check({vecs[i].name, ".PCSrcE"}, 32'(PCSrcE), 32'(vecs[i].expSrc));
      check({vecs[i].name, ".PCTargetE"}, PCTargetE, vecs[i].expTgt);
      check({vecs[i].name, ".stallE"}, 32'(stallE), 32'd0);
      pushExp(vecs[i], vecs[i].expAlu);
      @(posedge clk);
      #1;
      checkEm();
    end

    // Mid-cycle asynchronous reset clears the just-captured store at once.
    #2;
    rst = 1'b1;
    #1;
    checkZero("midreset");
    @(negedge clk);
    rst = 1'b0;

`ifdef MUL_EN
    @(negedge clk);
    runMul("mul_a", 32'h0000FFFF, 32'h00010001, 5'd5, 32'hFFFFFFFF);
    @(negedge clk);
    runMul("mul_b2b", 32'h12345678, 32'd9, 5'd6, 32'hA3D70A38);

    // Abort in the middle of BUSY, then reissue from a clean start.
    @(negedge clk);
    drive(mulVec("mul_abort", 32'd3, 32'd5, 5'd3));
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("abort.stall_before", 32'(stallE), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.stall_during_rst", 32'(stallE), 32'd0);
    check("abort.ALUResultM", ALUResultM, 32'h0);
    rst = 1'b0;
    runMul("mul_reissue", 32'd3, 32'd5, 5'd3, 32'd15);
`else
    @(negedge clk);
    begin
      vec_t v;
      v = mulVec("mul_off", 32'h0000FFFF, 32'h00010001, 5'd5);
      drive(v);
      #1;
      check("mul_off.stallE", 32'(stallE), 32'd0);
      pushExp(v, 32'h0);
      @(posedge clk);
      #1;
      checkEm();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
